// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Ports: Clk, Reset (sync, active-high), Start/Op/A/B issue, Read_Req
// (mfhi/mflo), Flush (squash); HI/LO results, Busy, Done pulse, Stall.
// Optional: define MULDIV_EARLY_TERM_EN to end a multiply once the
// shifted multiplier runs out of set bits.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Read_Req,
  input  logic             Flush,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done,
  output logic             Stall
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIXUP
  } state_e;

  state_e             state_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   opb_q;
  logic [CW-1:0]      cnt_q;
  logic               is_div_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  logic               a_sgn;
  logic               b_sgn;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] mul_acc_d;
  logic [WIDTH:0]     trial;
  logic               fits;
  logic [WIDTH-1:0]   rem_d;
  logic [2*WIDTH-1:0] div_acc_d;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               early;

  always_comb begin
    a_sgn = ~Op[0] & A[WIDTH-1];
    b_sgn = ~Op[0] & B[WIDTH-1];
    a_mag = a_sgn ? -A : A;
    b_mag = b_sgn ? -B : B;

    mul_acc_d = acc_q + (opb_q[0] ? mcand_q : '0);

    // acc holds {rem, dividend/quotient}; the top W+1 bits are
    // {rem, next dividend bit}, so the trial needs one guard bit.
    trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
    fits  = ~trial[WIDTH];
    rem_d = fits ? trial[WIDTH-1:0] : acc_q[2*WIDTH-2:WIDTH-1];
    div_acc_d = {rem_d, acc_q[WIDTH-2:0], fits};

    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH]
                         : acc_q[2*WIDTH-1:WIDTH];
`ifdef MULDIV_EARLY_TERM_EN
    early = ~is_div_q & (opb_q[WIDTH-1:1] == '0);
`else
    early = 1'b0;
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (Start && !Flush) begin
            is_div_q <= Op[1];
            cnt_q    <= '0;
            if (Op[1] && B == '0) begin
              acc_q     <= {A, {WIDTH{1'b1}}};
              mcand_q   <= '0;
              opb_q     <= '0;
              neg_res_q <= 1'b0;
              neg_rem_q <= 1'b0;
              state_q   <= FIXUP;
            end else begin
              acc_q     <= Op[1] ? {{WIDTH{1'b0}}, a_mag} : '0;
              mcand_q   <= Op[1] ? '0 : {{WIDTH{1'b0}}, a_mag};
              opb_q     <= b_mag;
              neg_res_q <= a_sgn ^ b_sgn;
              neg_rem_q <= a_sgn;
              state_q   <= RUN;
            end
          end
        end
        RUN: begin
          if (Flush) begin
            state_q <= IDLE;
          end else begin
            if (is_div_q) begin
              acc_q <= div_acc_d;
            end else begin
              acc_q   <= mul_acc_d;
              mcand_q <= mcand_q << 1;
              opb_q   <= opb_q >> 1;
            end
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST || early) state_q <= FIXUP;
          end
        end
        FIXUP: begin
          if (!Flush) begin
            hi_q   <= is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
            lo_q   <= is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
            done_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign HI    = hi_q;
  assign LO    = lo_q;
  assign Done  = done_q;
  assign Busy  = (state_q != IDLE);
  assign Stall = Busy & (Start | Read_Req);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vectors for muldiv_sequencer.
// Checks latency, HI/LO results, Stall, Flush and Reset behaviour.
module tb_muldiv_sequencer;

  logic        Clk = 1'b0;
  logic        Reset, Start, Read_Req, Flush;
  logic [1:0]  Op;
  logic [31:0] A, B, HI, LO;
  logic        Busy, Done, Stall;

  int n_chk = 0;
  int n_fail = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Read_Req(Read_Req), .Flush(Flush), .HI(HI), .LO(LO),
    .Busy(Busy), .Done(Done), .Stall(Stall)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] ehi,
                        input logic [31:0] elo);
    int n;
    Op = op; A = a; B = b; Start = 1'b1;
    tick();
    Start = 1'b0;
    n = 1;
    while (!Done && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_hi"}, 64'(HI), 64'(ehi));
    chk({tag, "_lo"}, 64'(LO), 64'(elo));
  endtask

  localparam int MULT = 0, MULTU = 1, DIV = 2, DIVU = 3;

`ifdef MULDIV_EARLY_TERM_EN
  localparam int LAT_M37 = 5;
  localparam logic [31:0] FL_B = 32'h8000_0006;
`else
  localparam int LAT_M37 = 34;
  localparam logic [31:0] FL_B = 32'd6;
`endif

  initial begin
    int n, sc, dn;
    logic [31:0] phi, plo;
    Reset = 1'b1; Start = 1'b0; Read_Req = 1'b0; Flush = 1'b0;
    Op = 2'd0; A = '0; B = '0;
    tick(); tick();
    chk("rst_hi", 64'(HI), 64'h0);
    chk("rst_lo", 64'(LO), 64'h0);
    chk("rst_busy", 64'(Busy), 64'h0);
    chk("rst_done", 64'(Done), 64'h0);
    Reset = 1'b0;
    tick();

    run_op("multu_max", 2'(MULTU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34,
           32'hFFFF_FFFE, 32'h0000_0001);
    chk("idle_stall", 64'(Stall), 64'h0);
    run_op("mult_m3x7", 2'(MULT), 32'hFFFF_FFFD, 32'd7, LAT_M37,
           32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div_m7_2", 2'(DIV), 32'hFFFF_FFF9, 32'd2, 34,
           32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_by0", 2'(DIVU), 32'd100, 32'd0, 2,
           32'd100, 32'hFFFF_FFFF);
    run_op("div_ovf", 2'(DIV), 32'h8000_0000, 32'hFFFF_FFFF, 34,
           32'h0, 32'h8000_0000);
    run_op("divu_big", 2'(DIVU), 32'hFFFF_FFFF, 32'h10, 34,
           32'hF, 32'h0FFF_FFFF);

    // Read_Req from t+5 stalls until the Done cycle
    Op = 2'(DIVU); A = 32'd1000; B = 32'd7; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick(); tick(); tick(); tick();
    Read_Req = 1'b1;
    sc = 0;
    for (int c = 5; c <= 33; c++) begin
      #1;
      if (Stall) sc++;
      tick();
    end
    #1;
    chk("rd_stall_cnt", 64'(sc), 64'd29);
    chk("rd_stall_end", 64'(Stall), 64'h0);
    chk("rd_done", 64'(Done), 64'h1);
    chk("rd_lo", 64'(LO), 64'd142);
    chk("rd_hi", 64'(HI), 64'd6);
    Read_Req = 1'b0;

    // Start issued in the Done cycle, then a held Start
    Op = 2'(DIVU); A = 32'd1000; B = 32'd7; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    Op = 2'(DIVU); A = 32'd77; B = 32'd5; Start = 1'b1;
    n = 2; sc = 0;
    while (!Done && n < 100) begin
      #1;
      if (Stall) sc++;
      tick();
      n++;
    end
    #1;
    chk("hold_lat", 64'(n), 64'd34);
    chk("hold_stalls", 64'(sc), 64'd32);
    chk("hold_nostall", 64'(Stall), 64'h0);
    chk("hold_lo1", 64'(LO), 64'd142);
    tick();
    Start = 1'b0;
    n = 1;
    while (!Done && n < 100) begin
      tick();
      n++;
    end
    chk("held_lat", 64'(n), 64'd34);
    chk("held_lo", 64'(LO), 64'd15);
    chk("held_hi", 64'(HI), 64'd2);

    // Flush in IDLE swallows a same-cycle Start
    Op = 2'(MULTU); A = 32'd5; B = 32'd6; Start = 1'b1; Flush = 1'b1;
    tick();
    Start = 1'b0; Flush = 1'b0;
    chk("flush_idle", 64'(Busy), 64'h0);

    // Flush mid-RUN drops the operation
    phi = HI; plo = LO;
    Op = 2'(MULTU); A = 32'd5; B = FL_B; Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    chk("flush_busy", 64'(Busy), 64'h0);
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      if (Done) dn++;
      tick();
    end
    chk("flush_nodone", 64'(dn), 64'h0);
    chk("flush_hi", 64'(HI), 64'(phi));
    chk("flush_lo", 64'(LO), 64'(plo));

    // Reset mid-RUN
    Op = 2'(MULT); A = 32'd9; B = 32'd9; Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("mrst_hi", 64'(HI), 64'h0);
    chk("mrst_lo", 64'(LO), 64'h0);
    chk("mrst_busy", 64'(Busy), 64'h0);
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      if (Done) dn++;
      tick();
    end
    chk("mrst_nodone", 64'(dn), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
